// File: rtl/multicore_mem_ctrl_if.sv
// rtl/multicore_mem_ctrl_if.sv - host, core and memory-side signal bundle for multicore_mem_ctrl
interface multicore_mem_ctrl_if #(
  parameter int N_CORES = 8,
  parameter int DW      = 16,
  parameter int AW      = 9,
  parameter int SW      = 4
);
  logic [2:0]            cmd;
  logic                  cmd_valid;
  logic [AW-1:0]         ext_addr;
  logic [SW-1:0]         ext_sel;
  logic                  ext_bcast;
  logic                  ext_we;
  logic                  ext_re;
  logic [DW-1:0]         ext_wdata;
  logic [DW-1:0]         ext_rdata;
  logic                  ext_rvalid;
  logic [N_CORES*DW-1:0] core_pc;
  logic [N_CORES*DW-1:0] core_ar;
  logic [N_CORES*DW-1:0] core_dout;
  logic [N_CORES-1:0]    core_dram_we;
  logic [N_CORES-1:0]    core_dram_re;
  logic [N_CORES-1:0]    core_iram_re;
  logic [N_CORES-1:0]    core_halt;
  logic                  core_start;
  logic [N_CORES*AW-1:0] iram_addr;
  logic [N_CORES-1:0]    iram_we;
  logic [N_CORES-1:0]    iram_re;
  logic [DW-1:0]         iram_wdata;
  logic [N_CORES*AW-1:0] dram_addr;
  logic [N_CORES*DW-1:0] dram_wdata;
  logic [N_CORES-1:0]    dram_we;
  logic [N_CORES-1:0]    dram_re;
  logic [N_CORES*DW-1:0] dram_rdata;
  logic [2:0]            state;
  logic [31:0]           cycle_count;
  logic                  run_done;
  logic                  timeout;

  modport master (
    output cmd, cmd_valid, ext_addr, ext_sel, ext_bcast, ext_we, ext_re, ext_wdata,
           core_pc, core_ar, core_dout, core_dram_we, core_dram_re, core_iram_re,
           core_halt, dram_rdata,
    input  ext_rdata, ext_rvalid, core_start, iram_addr, iram_we, iram_re, iram_wdata,
           dram_addr, dram_wdata, dram_we, dram_re, state, cycle_count, run_done, timeout
  );

  modport slave (
    input  cmd, cmd_valid, ext_addr, ext_sel, ext_bcast, ext_we, ext_re, ext_wdata,
           core_pc, core_ar, core_dout, core_dram_we, core_dram_re, core_iram_re,
           core_halt, dram_rdata,
    output ext_rdata, ext_rvalid, core_start, iram_addr, iram_we, iram_re, iram_wdata,
           dram_addr, dram_wdata, dram_we, dram_re, state, cycle_count, run_done, timeout
  );
endinterface

// File: rtl/multicore_mem_ctrl.sv
// rtl/multicore_mem_ctrl.sv - command-driven mode FSM steering host and core traffic to IRAMs and shared DRAM
module multicore_mem_ctrl #(
  parameter int          N_CORES    = 8,
  parameter int          DW         = 16,
  parameter int          AW         = 9,
  parameter int          SW         = 4,
  parameter int          RD_LAT     = 1,
  parameter int unsigned MAX_CYCLES = 65535
) (
  input logic                   clock,
  input logic                   reset,
  multicore_mem_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDI  = 3'd1,
    S_LDD  = 3'd2,
    S_RUN  = 3'd3,
    S_RDBK = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 32'd1);

  state_t                state_q, state_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic                  timeout_q, timeout_d;
  logic                  run_done_q, run_done_d;
  logic                  core_start_q, core_start_d;
  logic [N_CORES*AW-1:0] iram_addr_q, iram_addr_d;
  logic [N_CORES-1:0]    iram_we_q, iram_we_d;
  logic [N_CORES-1:0]    iram_re_q, iram_re_d;
  logic [DW-1:0]         iram_wdata_q, iram_wdata_d;
  logic [N_CORES*AW-1:0] dram_addr_q, dram_addr_d;
  logic [N_CORES*DW-1:0] dram_wdata_q, dram_wdata_d;
  logic [N_CORES-1:0]    dram_we_q, dram_we_d;
  logic [N_CORES-1:0]    dram_re_q, dram_re_d;
  logic [DW-1:0]         ext_rdata_q, ext_rdata_d;
  logic                  ext_rvalid_q, ext_rvalid_d;
  logic [RD_LAT:0]       rd_vld_q, rd_vld_d;
  logic [RD_LAT:0][SW-1:0] rd_sel_q, rd_sel_d;

  logic stop;
  logic sel_hit;
  logic unused_bits;

  assign stop        = bus.cmd_valid && (bus.cmd == 3'd0);
  assign unused_bits = ^{bus.core_pc, bus.core_ar};

  always_comb begin
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    iram_addr_d   = iram_addr_q;
    iram_wdata_d  = iram_wdata_q;
    dram_addr_d   = dram_addr_q;
    dram_wdata_d  = dram_wdata_q;
    ext_rdata_d   = ext_rdata_q;
    rd_sel_d      = rd_sel_q;
    iram_we_d     = '0;
    iram_re_d     = '0;
    dram_we_d     = '0;
    dram_re_d     = '0;
    ext_rvalid_d  = 1'b0;
    rd_vld_d      = '0;
    sel_hit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            3'd1: state_d = S_LDI;
            3'd2: state_d = S_LDD;
            3'd3: begin
              state_d       = S_RUN;
              cycle_count_d = '0;
              timeout_d     = 1'b0;
            end
            3'd4: state_d = S_RDBK;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LDI: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          iram_wdata_d = bus.ext_wdata;
          for (int i = 0; i < N_CORES; i++) begin
            iram_addr_d[i*AW +: AW] = bus.ext_addr;
            iram_we_d[i] = bus.ext_we & (bus.ext_bcast | (bus.ext_sel == SW'(i)));
          end
        end
      end
      S_LDD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          dram_addr_d[AW-1:0]  = bus.ext_addr;
          dram_wdata_d[DW-1:0] = bus.ext_wdata;
          dram_we_d[0]         = bus.ext_we;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < N_CORES; i++) begin
            iram_addr_d[i*AW +: AW]  = bus.core_pc[i*DW +: AW];
            dram_addr_d[i*AW +: AW]  = bus.core_ar[i*DW +: AW];
            dram_wdata_d[i*DW +: DW] = bus.core_dout[i*DW +: DW];
          end
          iram_re_d     = bus.core_iram_re;
          dram_we_d     = bus.core_dram_we;
          dram_re_d     = bus.core_dram_re;
          cycle_count_d = cycle_count_q + 32'd1;
          // Halt outranks the timeout when both land on the final cycle.
          if (&bus.core_halt) begin
            state_d = S_DONE;
          end else if (cycle_count_q == LAST_CYCLE) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      S_RDBK: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < N_CORES; i++) begin
            if (bus.ext_sel == SW'(i)) begin
              sel_hit                 = 1'b1;
              dram_addr_d[i*AW +: AW] = bus.ext_addr;
              dram_re_d[i]            = bus.ext_re;
            end
          end
          rd_vld_d[0] = bus.ext_re & sel_hit;
          rd_sel_d[0] = bus.ext_sel;
          for (int j = 1; j <= RD_LAT; j++) begin
            rd_vld_d[j] = rd_vld_q[j-1];
            rd_sel_d[j] = rd_sel_q[j-1];
          end
          // The last stage lines up with the DRAM returning data for its port.
          if (rd_vld_q[RD_LAT]) begin
            ext_rvalid_d = 1'b1;
            for (int i = 0; i < N_CORES; i++) begin
              if (rd_sel_q[RD_LAT] == SW'(i)) ext_rdata_d = bus.dram_rdata[i*DW +: DW];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    core_start_d = (state_d == S_RUN);
    run_done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
      run_done_q    <= 1'b0;
      core_start_q  <= 1'b0;
      iram_addr_q   <= '0;
      iram_we_q     <= '0;
      iram_re_q     <= '0;
      iram_wdata_q  <= '0;
      dram_addr_q   <= '0;
      dram_wdata_q  <= '0;
      dram_we_q     <= '0;
      dram_re_q     <= '0;
      ext_rdata_q   <= '0;
      ext_rvalid_q  <= 1'b0;
      rd_vld_q      <= '0;
      rd_sel_q      <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
      run_done_q    <= run_done_d;
      core_start_q  <= core_start_d;
      iram_addr_q   <= iram_addr_d;
      iram_we_q     <= iram_we_d;
      iram_re_q     <= iram_re_d;
      iram_wdata_q  <= iram_wdata_d;
      dram_addr_q   <= dram_addr_d;
      dram_wdata_q  <= dram_wdata_d;
      dram_we_q     <= dram_we_d;
      dram_re_q     <= dram_re_d;
      ext_rdata_q   <= ext_rdata_d;
      ext_rvalid_q  <= ext_rvalid_d;
      rd_vld_q      <= rd_vld_d;
      rd_sel_q      <= rd_sel_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.timeout     = timeout_q;
  assign bus.run_done    = run_done_q;
  assign bus.core_start  = core_start_q;
  assign bus.iram_addr   = iram_addr_q;
  assign bus.iram_we     = iram_we_q;
  assign bus.iram_re     = iram_re_q;
  assign bus.iram_wdata  = iram_wdata_q;
  assign bus.dram_addr   = dram_addr_q;
  assign bus.dram_wdata  = dram_wdata_q;
  assign bus.dram_we     = dram_we_q;
  assign bus.dram_re     = dram_re_q;
  assign bus.ext_rdata   = ext_rdata_q;
  assign bus.ext_rvalid  = ext_rvalid_q;
endmodule

// File: tb/tb_multicore_mem_ctrl.sv
// tb/tb_multicore_mem_ctrl.sv - vector table plus readback scoreboard bench for multicore_mem_ctrl
module tb_multicore_mem_ctrl;
  localparam int NC     = 8;
  localparam int DW     = 16;
  localparam int AW     = 9;
  localparam int SW     = 4;
  localparam int RD_LAT = 1;
  localparam int MAXC   = 120;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;

  multicore_mem_ctrl_if #(.N_CORES(NC), .DW(DW), .AW(AW), .SW(SW)) bus();

  multicore_mem_ctrl #(
    .N_CORES(NC), .DW(DW), .AW(AW), .SW(SW), .RD_LAT(RD_LAT), .MAX_CYCLES(MAXC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [DW-1:0] mem    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem[a]    = DW'(a) ^ 16'h5A5A;
      shadow[a] = DW'(a) ^ 16'h5A5A;
    end
  end

  always @(posedge clock) begin
    for (int p = 0; p < NC; p++) begin
      if (bus.dram_we[p]) mem[bus.dram_addr[p*AW +: AW]] <= bus.dram_wdata[p*DW +: DW];
      if (bus.dram_re[p]) bus.dram_rdata[p*DW +: DW] <= mem[bus.dram_addr[p*AW +: AW]];
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.run_done) n_done++;
      if (bus.ext_rvalid) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 64'(bus.ext_rvalid), 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rdata", 64'(bus.ext_rdata), 64'(e.data));
          chk("rvalid_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        exp_t e;
        e = sbq.pop_front();
        chk("rvalid_missing", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd_go(input logic [2:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
  endtask

  task automatic rd(input logic [SW-1:0] sel, input logic [AW-1:0] addr, input bit expect_data);
    bus.ext_sel  = sel;
    bus.ext_addr = addr;
    bus.ext_re   = 1'b1;
    if (expect_data) sbq.push_back('{data: shadow[addr], due: cyc + RD_LAT + 2});
    step();
  endtask

  task automatic ldd_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.ext_addr  = addr;
    bus.ext_wdata = data;
    bus.ext_we    = 1'b1;
    shadow[addr]  = data;
    step();
    chk("ldd_we", 64'(bus.dram_we), 64'h01);
    chk("ldd_addr", 64'(bus.dram_addr[AW-1:0]), 64'(addr));
    chk("ldd_wdata", 64'(bus.dram_wdata[DW-1:0]), 64'(data));
  endtask

  typedef struct {
    logic          bcast;
    logic [SW-1:0] sel;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NC-1:0] exp_we;
  } ldi_vec_t;

  ldi_vec_t vec[6];
  int       done_base;

  initial begin
    vec[0] = '{1'b1, 4'd0, 1'b1, 9'd5,   16'hABCD, 8'hFF};
    vec[1] = '{1'b0, 4'd2, 1'b1, 9'd5,   16'h1111, 8'h04};
    vec[2] = '{1'b0, 4'd7, 1'b1, 9'h1FF, 16'h2222, 8'h80};
    vec[3] = '{1'b0, 4'd9, 1'b1, 9'd8,   16'h3333, 8'h00};
    vec[4] = '{1'b1, 4'd3, 1'b0, 9'd9,   16'h4444, 8'h00};
    vec[5] = '{1'b0, 4'd0, 1'b1, 9'h0AA, 16'h5555, 8'h01};

    bus.cmd = 3'd0; bus.cmd_valid = 1'b0;
    bus.ext_addr = '0; bus.ext_sel = '0; bus.ext_bcast = 1'b0;
    bus.ext_we = 1'b0; bus.ext_re = 1'b0; bus.ext_wdata = '0;
    bus.core_pc = '0; bus.core_ar = '0; bus.core_dout = '0;
    bus.core_dram_we = '0; bus.core_dram_re = '0; bus.core_iram_re = '0;
    bus.core_halt = '0;

    step(); step();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_iram_we", 64'(bus.iram_we), 64'd0);
    chk("rst_dram_re", 64'(bus.dram_re), 64'd0);
    chk("rst_cycle_count", 64'(bus.cycle_count), 64'd0);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    chk("rst_core_start", 64'(bus.core_start), 64'd0);
    reset = 1'b0;
    step();

    cmd_go(3'd1);
    chk("ldi_state", 64'(bus.state), 64'd1);
    for (int v = 0; v < 6; v++) begin
      bus.ext_bcast = vec[v].bcast;
      bus.ext_sel   = vec[v].sel;
      bus.ext_we    = vec[v].we;
      bus.ext_addr  = vec[v].addr;
      bus.ext_wdata = vec[v].data;
      step();
      chk($sformatf("ldi_we[%0d]", v), 64'(bus.iram_we), 64'(vec[v].exp_we));
      chk($sformatf("ldi_wdata[%0d]", v), 64'(bus.iram_wdata), 64'(vec[v].data));
      chk($sformatf("ldi_addr0[%0d]", v), 64'(bus.iram_addr[0 +: AW]), 64'(vec[v].addr));
      chk($sformatf("ldi_addr7[%0d]", v), 64'(bus.iram_addr[7*AW +: AW]), 64'(vec[v].addr));
    end
    bus.ext_we = 1'b0;
    cmd_go(3'd3);
    chk("ldi_run_ignored", 64'(bus.state), 64'd1);
    chk("ldi_idle_we", 64'(bus.iram_we), 64'd0);

    bus.ext_bcast = 1'b1; bus.ext_we = 1'b1;
    step();
    chk("ldi_pre_reset_we", 64'(bus.iram_we), 64'hFF);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", 64'(bus.iram_we), 64'd0);
    chk("async_rst_state", 64'(bus.state), 64'd0);
    chk("async_rst_addr", 64'(bus.iram_addr), 64'd0);
    bus.ext_we = 1'b0; bus.ext_bcast = 1'b0;
    step();
    reset = 1'b0;
    step();

    cmd_go(3'd2);
    chk("ldd_state", 64'(bus.state), 64'd2);
    ldd_write(9'h1F0, 16'h1234);
    ldd_write(9'h010, 16'hBEEF);
    ldd_write(9'h011, 16'h0F0F);
    bus.ext_we = 1'b0;
    cmd_go(3'd0);
    chk("ldd_stop_state", 64'(bus.state), 64'd0);
    chk("ldd_stop_we", 64'(bus.dram_we), 64'd0);

    cmd_go(3'd4);
    chk("rdbk_state", 64'(bus.state), 64'd4);
    rd(4'd3, 9'h1F0, 1'b1);
    chk("rdbk_re", 64'(bus.dram_re), 64'h08);
    chk("rdbk_addr3", 64'(bus.dram_addr[3*AW +: AW]), 64'h1F0);
    bus.ext_re = 1'b0;
    step(); step(); step();
    rd(4'd3, 9'h010, 1'b1);
    rd(4'd5, 9'h011, 1'b1);
    rd(4'd0, 9'h1F0, 1'b1);
    bus.ext_re = 1'b0;
    step(); step(); step();
    rd(4'd9, 9'h010, 1'b0);
    chk("rdbk_oob_re", 64'(bus.dram_re), 64'd0);
    bus.ext_re = 1'b0;
    step(); step(); step();
    rd(4'd2, 9'h010, 1'b0);
    bus.ext_re = 1'b0;
    cmd_go(3'd0);
    chk("rdbk_exit_state", 64'(bus.state), 64'd0);
    step(); step(); step();

    bus.core_pc[4*DW +: DW] = 16'h0107;
    bus.core_ar[4*DW +: DW] = 16'h0022;
    bus.core_dram_we = 8'h10;
    bus.core_iram_re = 8'hFF;
    done_base = n_done;
    cmd_go(3'd3);
    step();
    chk("run_state", 64'(bus.state), 64'd3);
    chk("run_core_start", 64'(bus.core_start), 64'd1);
    chk("run_iram_addr4", 64'(bus.iram_addr[4*AW +: AW]), 64'h107);
    chk("run_dram_addr4", 64'(bus.dram_addr[4*AW +: AW]), 64'h022);
    chk("run_dram_we", 64'(bus.dram_we), 64'h10);
    chk("run_iram_re", 64'(bus.iram_re), 64'hFF);
    chk("run_cc1", 64'(bus.cycle_count), 64'd1);
    for (int k = 2; k <= 99; k++) step();
    bus.core_halt = 8'hFF;
    step();
    chk("halt_state", 64'(bus.state), 64'd5);
    chk("halt_run_done", 64'(bus.run_done), 64'd1);
    chk("halt_cc", 64'(bus.cycle_count), 64'd100);
    chk("halt_timeout", 64'(bus.timeout), 64'd0);
    chk("halt_core_start", 64'(bus.core_start), 64'd0);
    bus.core_halt = 8'h00;
    step();
    chk("halt_idle", 64'(bus.state), 64'd0);
    chk("halt_idle_we", 64'(bus.dram_we), 64'd0);
    chk("halt_done_pulses", 64'(n_done - done_base), 64'd1);

    bus.core_halt = 8'h7F;
    cmd_go(3'd3);
    for (int k = 1; k < MAXC; k++) step();
    chk("to_still_run", 64'(bus.state), 64'd3);
    chk("to_not_yet", 64'(bus.timeout), 64'd0);
    step();
    chk("to_state", 64'(bus.state), 64'd5);
    chk("to_timeout", 64'(bus.timeout), 64'd1);
    chk("to_cc", 64'(bus.cycle_count), 64'(MAXC));
    cmd_go(3'd1);
    chk("done_cmd_ignored", 64'(bus.state), 64'd0);
    step(); step(); step();
    chk("to_sticky", 64'(bus.timeout), 64'd1);
    cmd_go(3'd3);
    chk("rerun_timeout_clr", 64'(bus.timeout), 64'd0);
    chk("rerun_cc_clr", 64'(bus.cycle_count), 64'd0);
    for (int k = 1; k < MAXC; k++) step();
    bus.core_halt = 8'hFF;
    step();
    chk("tie_state", 64'(bus.state), 64'd5);
    chk("tie_timeout", 64'(bus.timeout), 64'd0);
    chk("tie_cc", 64'(bus.cycle_count), 64'(MAXC));
    bus.core_halt = 8'h00;
    step();

    bus.core_dram_re = 8'h03;
    done_base = n_done;
    cmd_go(3'd3);
    for (int k = 1; k <= 10; k++) step();
    chk("stop_pre_cc", 64'(bus.cycle_count), 64'd10);
    chk("stop_pre_we", 64'(bus.dram_we), 64'h10);
    cmd_go(3'd0);
    chk("stop_state", 64'(bus.state), 64'd0);
    chk("stop_core_start", 64'(bus.core_start), 64'd0);
    chk("stop_dram_we", 64'(bus.dram_we), 64'd0);
    chk("stop_dram_re", 64'(bus.dram_re), 64'd0);
    chk("stop_iram_re", 64'(bus.iram_re), 64'd0);
    chk("stop_cc_hold", 64'(bus.cycle_count), 64'd10);
    step(); step(); step();
    chk("stop_no_done", 64'(n_done - done_base), 64'd0);
    chk("stop_no_timeout", 64'(bus.timeout), 64'd0);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicore_mem_ctrl.md
Name: multicore_mem_ctrl

Overview:
- Parametrised memory-access controller for an N-core array with per-core IRAMs and one N-port shared DRAM.
- Replaces ad-hoc start/load flags with an explicit command-driven mode FSM.
- Modes: IRAM load (per-core or broadcast), DRAM load, run with halt/timeout detection, and DRAM readback from any port.
- Sits between the external loader/host interface and the core/IRAM/DRAM instances.

Parameters:
N_CORES, 8, number of cores/IRAMs/DRAM ports (1..16)
DW, 16, data width
AW, 9, IRAM/DRAM address width
SW, 4, core-select width (2^SW >= N_CORES)
RD_LAT, 1, DRAM read latency in cycles (1..4)
MAX_CYCLES, 65535, run timeout in cycles (>0, < 2^32)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd  in  3  command code: 0 STOP, 1 LOAD_IRAM, 2 LOAD_DRAM, 3 RUN, 4 READBACK
cmd_valid  in  1  command strobe
ext_addr  in  AW  external address
ext_sel  in  SW  target core/port
ext_bcast  in  1  LOAD_IRAM: write all IRAMs
ext_we  in  1  external write strobe
ext_re  in  1  external read strobe (READBACK)
ext_wdata  in  DW  external write data
ext_rdata  out  DW  readback data
ext_rvalid  out  1  readback data valid, 1-cycle pulse
core_pc  in  N_CORES*DW  packed core PCs, core i at [i*DW +: DW]
core_ar  in  N_CORES*DW  packed core address registers
core_dout  in  N_CORES*DW  packed core store data
core_dram_we  in  N_CORES  core DRAM write requests
core_dram_re  in  N_CORES  core DRAM read requests
core_iram_re  in  N_CORES  core IRAM read requests
core_halt  in  N_CORES  core has executed END
core_start  out  1  core enable, high only in RUN
iram_addr  out  N_CORES*AW  packed IRAM addresses
iram_we  out  N_CORES  IRAM write enables
iram_re  out  N_CORES  IRAM read enables
iram_wdata  out  DW  shared IRAM write data
dram_addr  out  N_CORES*AW  packed DRAM port addresses
dram_wdata  out  N_CORES*DW  packed DRAM port write data
dram_we  out  N_CORES  DRAM port write enables
dram_re  out  N_CORES  DRAM port read enables
dram_rdata  in  N_CORES*DW  packed DRAM port read data
state  out  3  0 IDLE, 1 LD_I, 2 LD_D, 3 RUN, 4 RDBK, 5 DONE
cycle_count  out  32  cycles spent in last/current RUN
run_done  out  1  1-cycle pulse on RUN completion
timeout  out  1  sticky; last RUN ended by MAX_CYCLES

Behaviour:
- Reset (async): state IDLE; every output and internal register 0, including cycle_count and timeout.
- All memory-side outputs are registered: a value sampled at edge k appears after edge k.

FSM:
- IDLE + cmd_valid selects the mode: 1→LD_I, 2→LD_D, 3→RUN, 4→RDBK.
- Codes 0 and 5–7 in IDLE are ignored.
- In any non-IDLE state except DONE, cmd_valid with cmd=0 returns to IDLE next edge; other codes are ignored.
- STOP in RUN aborts: cycle_count holds its value, run_done is not asserted, timeout is not set.

LD_I:
- iram_addr[i] <= ext_addr for all i; iram_wdata <= ext_wdata.
- iram_we[i] <= ext_we & (ext_bcast | ext_sel==i).
- ext_sel >= N_CORES with bcast=0 produces no write.

LD_D:
- Port 0 only: dram_addr[0] <= ext_addr, dram_wdata[0] <= ext_wdata, dram_we[0] <= ext_we.
- All other ports' we/re are 0.

RUN:
- core_start=1.
- iram_addr[i] <= core_pc[i][AW-1:0]; iram_re <= core_iram_re.
- dram_addr[i] <= core_ar[i][AW-1:0]; dram_wdata[i] <= core_dout[i].
- dram_we <= core_dram_we; dram_re <= core_dram_re.
- On entry cycle_count <= 0 and timeout <= 0; it increments each RUN cycle.
- Exit to DONE when &core_halt, or when cycle_count reaches MAX_CYCLES-1 (sets timeout).
- Both conditions on the same cycle: timeout=0 (halt wins).

DONE:
- Lasts exactly one cycle; run_done=1 and core_start=0; next state IDLE.
- cmd_valid in DONE is ignored.

RDBK:
- Port p = ext_sel: dram_addr[p] <= ext_addr, dram_re[p] <= ext_re.
- ext_rdata <= dram_rdata[p] with ext_rvalid=1 exactly RD_LAT+1 cycles after the edge sampling ext_re. p is captured in a RD_LAT+1-deep pipeline.
- Back-to-back reads are supported (one per cycle).
- ext_sel out of range: no read issued, no rvalid.
- Leaving RDBK flushes the pipeline; no rvalid after exit.

Outside the owning mode:
- All we/re outputs are 0.
- Addresses and data hold their last values.
- ext_we/ext_re are ignored.

Reset mid-operation: immediate return to IDLE with all enables 0, including a write in flight.

Test Plan:
- Reset, then cmd=1 with bcast=1, ext_we=1, addr=5, data=0xABCD → iram_we=all ones one cycle later, iram_addr[i]=5, iram_wdata=0xABCD; then bcast=0, sel=2 → iram_we=0b00000100.
- LD_D, write addr 0x1F0 data 0x1234; RDBK sel=3 read addr 0x1F0 with RD_LAT=1 → dram_re[3] pulses; ext_rvalid asserts 2 cycles after read, ext_rdata=0x1234 (model returns it); back-to-back reads of 3 addresses give 3 consecutive rvalid pulses.
- RUN with core_pc[4]=0x0107, core_dram_we[4]=1, core_ar[4]=0x0022 → iram_addr[4]=0x107, dram_we[4]=1, dram_addr[4]=0x22 next cycle; halt all cores at cycle 100 → single run_done pulse, cycle_count=100 (±registered-edge count as defined), timeout=0, state returns to 0.
- RUN with MAX_CYCLES=50, core 7 never halts → DONE after 50 cycles, timeout=1 sticky until next RUN; halt arriving on the final cycle → timeout=0.
- STOP during RUN at cycle 10 → IDLE, core_start=0, all enables 0, no run_done; cmd=3 issued mid-LD_I ignored.
- Assert reset during LD_I write → all outputs 0 asynchronously, state=0; ext_sel=9 in RDBK → no dram_re, no rvalid.
